// File: rtl/led_bounce_monitor.sv
// Receive-side checker for the bouncing one-hot LED shifter: decodes position, direction, bounce count.
// Define LED_MON_STALL_TIMEOUT_EN to fault on more than STALL_MAX consecutive repeats while in TRACK.
module led_bounce_monitor #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned POS_W     = 3,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned STALL_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] led_in,
    input  logic             err_clr,
    output logic [POS_W-1:0] pos,
    output logic             pos_valid,
    output logic             dir,
    output logic             locked,
    output logic [CNT_W-1:0] bounce_cnt,
    output logic             err_pulse,
    output logic             err_sticky
);

    if (WIDTH < 3) begin : g_chk_width
        $error("led_bounce_monitor: WIDTH must be at least 3");
    end
    if (POS_W != $clog2(WIDTH)) begin : g_chk_pos_w
        $error("led_bounce_monitor: POS_W must equal clog2(WIDTH)");
    end
    if (STALL_MAX < 1) begin : g_chk_stall
        $error("led_bounce_monitor: STALL_MAX must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] bounce_q, bounce_d;
    logic             err_pulse_q, err_sticky_q, err_sticky_d;

    logic             is_zero, is_onehot;
    logic [POS_W-1:0] p;
    logic [POS_W:0]   p_ext, pos_ext;
    logic             step_up, step_dn, same_p;
    logic             err, advance;

`ifdef LED_MON_STALL_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
`endif

    // Sample classification and index of the set bit.
    always_comb begin
        is_zero   = (led_in == '0);
        is_onehot = !is_zero && ((led_in & (led_in - WIDTH'(1))) == '0);
        p         = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (led_in[i]) p = POS_W'(i);
        end
    end

    // Neighbour tests in one extra bit so pos+1 at the top and p+1 at the bottom cannot wrap.
    assign p_ext   = {1'b0, p};
    assign pos_ext = {1'b0, pos_q};
    assign step_up = (p_ext == pos_ext + 1'b1);
    assign step_dn = (p_ext + 1'b1 == pos_ext);
    assign same_p  = (p == pos_q);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        bounce_d = bounce_q;
        err      = 1'b0;
        advance  = 1'b0;
`ifdef LED_MON_STALL_TIMEOUT_EN
        stall_d  = sample_en ? '0 : stall_q;
`endif
        if (sample_en) begin
            unique case (state_q)
                IDLE: begin
                    if (is_onehot) begin
                        state_d = ACQUIRE;
                        pos_d   = p;
                    end else if (!is_zero) begin
                        state_d = FAULT;
                        err     = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (is_zero) begin
                        state_d = IDLE;
                    end else if (is_onehot && same_p) begin
                        state_d = ACQUIRE;
                    end else if (is_onehot && (step_up || step_dn)) begin
                        state_d = TRACK;
                        dir_d   = step_up;
                        pos_d   = p;
                        advance = 1'b1;
                    end else begin
                        state_d = FAULT;
                        err     = 1'b1;
                    end
                end
                TRACK: begin
                    if (is_zero) begin
                        state_d = IDLE;
                    end else if (is_onehot && (dir_q ? step_up : step_dn)) begin
                        pos_d   = p;
                        advance = 1'b1;
                    end else if (is_onehot && same_p) begin
`ifdef LED_MON_STALL_TIMEOUT_EN
                        if (stall_q == STALL_W'(STALL_MAX)) begin
                            state_d = FAULT;
                            err     = 1'b1;
                        end else begin
                            stall_d = stall_q + 1'b1;
                        end
`else
                        state_d = TRACK;
`endif
                    end else begin
                        state_d = FAULT;
                        err     = 1'b1;
                    end
                end
                FAULT: begin
                    if (is_zero) begin
                        state_d = IDLE;
                    end else if (is_onehot) begin
                        state_d = ACQUIRE;
                        pos_d   = p;
                    end else begin
                        err     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // End rule: reaching either end reverses direction and counts one bounce.
        if (advance && (p == '0 || p == LAST_IDX)) begin
            dir_d = (p == '0);
            if (bounce_q != '1) bounce_d = bounce_q + 1'b1;
        end

        if (err) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pos_q        <= '0;
            dir_q        <= 1'b0;
            bounce_q     <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            bounce_q     <= bounce_d;
            err_pulse_q  <= err;
            err_sticky_q <= err_sticky_d;
        end
    end

`ifdef LED_MON_STALL_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    assign pos        = pos_q;
    assign dir        = dir_q;
    assign bounce_cnt = bounce_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign pos_valid  = (state_q == ACQUIRE) || (state_q == TRACK);
    assign locked     = (state_q == TRACK);

endmodule
